// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : imem_arbiter_pkg
// Brief    : Shared widths, FSM state and owner encodings for imem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package imem_arbiter_pkg;

    localparam int c_WORD = 32;
    localparam int c_ADDR = 32;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    localparam logic c_OWN_IF = 1'b0;
    localparam logic c_OWN_D  = 1'b1;

    // RESP doubles as an idle cycle so a new grant can overlap the response.
    function automatic logic is_grant_state(input logic [1:0] st);
        return (st == c_ST_IDLE) || (st == c_ST_RESP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_arbiter_arb_prio.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter_arb_prio
// Brief    : Data-priority grant with a saturating starvation counter that
//            forces a fetch grant after STARVE consecutive data grants.
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter_arb_prio #(
    parameter int STARVE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_grant_en,
    input  logic i_req_if,
    input  logic i_req_d,
    output logic o_gnt_if,
    output logic o_gnt_d
);

    localparam int              c_SW         = $clog2(STARVE + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE);
    localparam logic [c_SW-1:0] c_ONE        = c_SW'(1);

    logic [c_SW-1:0] r_starve_cnt;
    logic            w_starved;

    assign w_starved = (r_starve_cnt == c_STARVE_MAX);

    always_comb begin
        o_gnt_if = 1'b0;
        o_gnt_d  = 1'b0;
        if (i_grant_en) begin
            if (i_req_d && !(i_req_if && w_starved)) begin
                o_gnt_d = 1'b1;
            end else if (i_req_if) begin
                o_gnt_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (o_gnt_if) begin
            r_starve_cnt <= '0;
        end else if (o_gnt_d && i_req_if && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + c_ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Brief    : Shares one fixed-latency memory between instruction fetch and
//            load/store, with data priority, starvation guard and fetch flush.
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int WORD   = c_WORD,
    parameter int ADDR   = c_ADDR,
    parameter int LAT    = 1,
    parameter int STARVE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [ADDR-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_v,
    output logic [WORD-1:0] if_inst,
    output logic            if_done,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [ADDR-1:0] d_addr,
    input  logic [WORD-1:0] d_wdata,
    output logic            d_v,
    output logic [WORD-1:0] d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [ADDR-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata
);

    localparam int              c_CW       = $clog2(LAT + 1);
    localparam logic [c_CW-1:0] c_LAT_LOAD = c_CW'(LAT);
    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_owner;
    logic            r_drop;
    logic [c_CW-1:0] r_wait_cnt;
    logic [ADDR-1:0] r_addr;
    logic            r_we;
    logic [WORD-1:0] r_wdata;
    logic [WORD-1:0] r_if_inst;
    logic [WORD-1:0] r_d_rdata;

    logic w_grant_en;
    logic w_gnt_if;
    logic w_gnt_d;
    logic w_gnt;
    logic w_capture;
    logic w_fetch_busy;

    assign w_grant_en   = is_grant_state(r_state);
    assign w_gnt        = w_gnt_if | w_gnt_d;
    assign w_capture    = (r_state == c_ST_WAIT) && (r_wait_cnt == c_ONE);
    assign w_fetch_busy = (r_owner == c_OWN_IF) && (r_state != c_ST_IDLE);

    imem_arbiter_arb_prio #(
        .STARVE (STARVE)
    ) u_arb_prio (
        .clk        (clk),
        .rst        (rst),
        .i_grant_en (w_grant_en),
        .i_req_if   (if_req),
        .i_req_d    (d_req),
        .o_gnt_if   (w_gnt_if),
        .o_gnt_d    (w_gnt_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        if_v        = 1'b0;
        if_done     = 1'b0;
        d_v         = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_gnt) begin
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                mem_en      = 1'b1;
                mem_we      = r_we;
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (r_wait_cnt == c_ONE) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                // A flush arriving in this very cycle still kills the pulse.
                if (r_owner == c_OWN_IF) begin
                    if_done = 1'b1;
                    if_v    = !r_drop && !if_flush;
                end else begin
                    d_v = 1'b1;
                end
                w_state_nxt = w_gnt ? c_ST_ISSUE : c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner    <= c_OWN_IF;
            r_drop     <= 1'b0;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_if_inst  <= '0;
            r_d_rdata  <= '0;
        end else begin
            // A fresh grant owns the drop flag; a flush only marks the old fetch.
            if (w_gnt) begin
                r_owner <= w_gnt_d ? c_OWN_D : c_OWN_IF;
                r_addr  <= w_gnt_d ? d_addr : if_addr;
                r_we    <= w_gnt_d & d_we;
                r_wdata <= w_gnt_d ? d_wdata : '0;
                r_drop  <= 1'b0;
            end else if (w_fetch_busy && if_flush) begin
                r_drop <= 1'b1;
            end

            if (r_state == c_ST_ISSUE) begin
                r_wait_cnt <= c_LAT_LOAD;
            end else if (r_state == c_ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - c_ONE;
            end

            if (w_capture) begin
                if (r_owner == c_OWN_D) begin
                    r_d_rdata <= mem_rdata;
                end else if (!r_drop && !if_flush) begin
                    r_if_inst <= mem_rdata;
                end
            end
        end
    end

    assign if_inst   = r_if_inst;
    assign d_rdata   = r_d_rdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Single-port memory arbiter and sequencer. Shares one fixed-latency memory between the instruction-fetch requester and the data (load/store) requester.
- Fetch responses drive the fetch stage's valid/instruction inputs.
- Data has priority, with a starvation guard that guarantees fetch progress.
- Supports fetch flush on branch so wrong-path instructions are discarded.

Parameters:
- WORD, 32, data/instruction width (from include/params.vh)
- ADDR, 32, address width (from include/params.vh)
- LAT, 1, memory read latency in cycles from mem_en to mem_rdata valid (>=1)
- STARVE, 4, max consecutive data grants while fetch is pending (>=1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_done pulse
- if_addr  in  ADDR  fetch address; stable while if_req high
- if_flush  in  1  branch taken: cancel in-flight/pending fetch
- if_v  out  1  fetch response valid (one-cycle pulse)
- if_inst  out  WORD  fetched instruction
- if_done  out  1  fetch transaction retired (pulse, also when flushed)
- d_req  in  1  data request; held until d_v
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR  data address
- d_wdata  in  WORD  write data
- d_v  out  1  data transaction complete (one-cycle pulse)
- d_rdata  out  WORD  read data
- mem_en  out  1  memory access strobe (one cycle per access)
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR  memory address
- mem_wdata  out  WORD  memory write data
- mem_rdata  in  WORD  memory read data, valid LAT cycles after mem_en

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0; counters and flags cleared; an in-flight access is abandoned with no response pulse.
- FSM states:
  - IDLE: in cycle t, if any request, grant it; latch owner, addr, we, wdata; next state ISSUE.
  - ISSUE (cycle t+1): mem_en=1 with registered addr/we/wdata; load wait counter to LAT; next state WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 0 (cycle t+1+LAT), capture mem_rdata into if_inst or d_rdata per owner; next state RESP.
  - RESP (cycle t+2+LAT): pulse if_v/if_done or d_v; this cycle behaves as IDLE, so a new grant may be made.
- Latency: request to response is LAT+2 cycles. Sustained throughput is 1 access per LAT+2 cycles.
- Arbitration when both requests are high in a grant cycle:
  - Data wins unless starve_cnt == STARVE.
  - starve_cnt increments on a data grant while if_req=1; clears on any fetch grant.
  - starve_cnt saturates at STARVE.
- Writes: d_v pulses on completion; d_rdata is still loaded from mem_rdata and its value is don't-care.
- Flush:
  - if_flush=1 while a fetch is owned (ISSUE/WAIT/RESP) sets the drop flag; the memory access still completes.
  - In RESP with drop set: if_v=0, if_done=1, if_inst not updated.
  - A flush in the RESP cycle itself also suppresses if_v.
  - A flush while in IDLE or serving data has no effect; the requester presents the new address.
- Requests deasserted before their response are a protocol violation; behaviour is unspecified. The bench asserts this never happens.
- if_v, d_v and if_done are never high when the respective owner did not hold the grant; if_v and d_v are never high in the same cycle.
- Counter width is clog2(LAT+1); the starve counter width is clog2(STARVE+1).

Decomposition:
- include/params.vh: WORD, ADDR, plus new localparams for the FSM state encodings (IDLE, ISSUE, WAIT, RESP) and owner encodings (OWN_IF, OWN_D).
- One natural sub-module: arb_prio, a combinational data-priority grant with a registered starvation counter. The remainder is a single module.

Test Plan:
- Fetch only, LAT=1, if_addr=0x10, mem returns 0xDEADBEEF → mem_en in cycle 1 with mem_addr=0x10; if_v=1 and if_inst=0xDEADBEEF in cycle 3.
- Simultaneous if_req and d_req read at 0x20 → data served first (d_v in cycle 3); fetch granted in cycle 3, if_v in cycle 6.
- d_req held high continuously with if_req high, STARVE=4 → exactly 4 data grants, then 1 fetch grant, then data resumes.
- Fetch in flight, if_flush pulsed in WAIT → if_v stays 0, if_done=1 in the RESP cycle, if_inst unchanged.
- Data write with d_we=1, d_addr=0x8, d_wdata=0x1234 → mem_en=1, mem_we=1, mem_wdata=0x1234 one cycle after grant; d_v LAT+2 cycles after request.
- rst driven low during WAIT, then released → all outputs 0 immediately; no response pulse; the next request is handled normally from IDLE.
